// File: rtl/ezusb_tx_framer.sv
// ezusb_tx_framer: wraps a user 16-bit word stream into frames for the FX3
// GPIF-II interface block: header {HDR_TAG, seq}, payload, length word
// {cont, count[14:0]} and, when EZUSB_TX_FRAMER_CSUM_EN is defined, a
// checksum word (sum of payload words mod 2^16). Frames longer than MAX_LEN
// are split; the length word of a split piece carries cont=1. After each
// frame a manual PKTEND is armed and the framer waits for PKTEND (low-active)
// or a timeout before the next frame may start.
//
// Handshake: a word transfers on the DI side in every cycle where
// DI_valid && DI_ready; DI/DI_valid never change while DI_valid && !DI_ready.
// On the user side a word is taken in every cycle where in_valid && in_ready.
module ezusb_tx_framer #(
    parameter int         MAX_LEN    = 1024,
    parameter logic [7:0] HDR_TAG    = 8'hA5,
    parameter int         PK_TIMEOUT = 65535
) (
    input  logic        ifclk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] DI,
    output logic        DI_valid,
    input  logic        DI_ready,
    output logic        pktend_arm,
    input  logic        PKTEND,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        pk_err,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_LEN     = 3'd3;
    localparam logic [2:0] S_CSUM    = 3'd4;
    localparam logic [2:0] S_ARM     = 3'd5;
    localparam logic [2:0] S_WAIT_PK = 3'd6;

    localparam logic [14:0] MAX_LEN_W = 15'(MAX_LEN);
    localparam logic [15:0] TMO_LAST  = 16'(PK_TIMEOUT - 1);

    logic [2:0]  state;
    logic [7:0]  seq;
    logic [14:0] cnt;
    logic        cont;
    logic        len_loaded;
    logic [15:0] timer;
`ifdef EZUSB_TX_FRAMER_CSUM_EN
    logic [15:0] csum;
`endif

    logic        load_ok;
    logic        word_moves;
    logic        in_take;
    logic [14:0] cnt_inc;
    logic        pk_done;

    assign load_ok    = !DI_valid || DI_ready;
    assign word_moves = DI_valid && DI_ready;
    assign in_ready   = (state == S_DATA) && load_ok;
    assign in_take    = in_valid && in_ready;
    assign cnt_inc    = cnt + 15'd1;
    // PKTEND seen, or the wait budget used up: either way the frame is closed.
    assign pk_done    = (state == S_WAIT_PK) && (!PKTEND || (timer == TMO_LAST));
    assign busy       = (state != S_IDLE);
    assign dbg_state  = state;

    // Frame sequencer and DI output register.
    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            DI         <= 16'h0000;
            DI_valid   <= 1'b0;
            pktend_arm <= 1'b0;
            seq        <= 8'h00;
            frame_cnt  <= 16'h0000;
            pk_err     <= 1'b0;
            cnt        <= 15'd0;
            cont       <= 1'b0;
            len_loaded <= 1'b0;
            timer      <= 16'h0000;
`ifdef EZUSB_TX_FRAMER_CSUM_EN
            csum       <= 16'h0000;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // DI_valid is always 0 here, so the header loads at once.
                    if (in_valid) begin
                        DI       <= {HDR_TAG, seq};
                        DI_valid <= 1'b1;
                        state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (word_moves) begin
                        DI_valid <= 1'b0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (in_take) begin
                        DI       <= in_data;
                        DI_valid <= 1'b1;
                        cnt      <= cnt_inc;
`ifdef EZUSB_TX_FRAMER_CSUM_EN
                        csum     <= csum + in_data;
`endif
                        // in_last wins over the split when both coincide.
                        if (in_last) begin
                            cont  <= 1'b0;
                            state <= S_LEN;
                        end else if (cnt_inc == MAX_LEN_W) begin
                            cont  <= 1'b1;
                            state <= S_LEN;
                        end
                    end else if (word_moves) begin
                        DI_valid <= 1'b0;
                    end
                end
                S_LEN: begin
                    // First phase waits for the last payload word to leave,
                    // second phase waits for the length word itself to leave.
                    if (!len_loaded) begin
                        if (load_ok) begin
                            DI         <= {cont, cnt};
                            DI_valid   <= 1'b1;
                            len_loaded <= 1'b1;
                        end
                    end else if (word_moves) begin
                        len_loaded <= 1'b0;
`ifdef EZUSB_TX_FRAMER_CSUM_EN
                        DI         <= csum;
                        DI_valid   <= 1'b1;
                        state      <= S_CSUM;
`else
                        DI_valid   <= 1'b0;
                        state      <= S_ARM;
`endif
                    end
                end
`ifdef EZUSB_TX_FRAMER_CSUM_EN
                S_CSUM: begin
                    if (word_moves) begin
                        DI_valid <= 1'b0;
                        state    <= S_ARM;
                    end
                end
`endif
                S_ARM: begin
                    pktend_arm <= 1'b1;
                    timer      <= 16'h0000;
                    state      <= S_WAIT_PK;
                end
                S_WAIT_PK: begin
                    if (pk_done) begin
                        // Dropping pktend_arm here guarantees a low cycle
                        // before the next frame can raise it again.
                        pktend_arm <= 1'b0;
                        seq        <= seq + 8'd1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        cnt        <= 15'd0;
`ifdef EZUSB_TX_FRAMER_CSUM_EN
                        csum       <= 16'h0000;
`endif
                        if (PKTEND) begin
                            pk_err <= 1'b1;
                        end
                        state      <= S_IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    DI_valid <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ezusb_tx_framer.sv
// Bench for ezusb_tx_framer (MAX_LEN=4, PK_TIMEOUT=16). Expected DI words go
// into exp_q and are popped by a monitor on every DI transfer. Checksum words
// are expected only when EZUSB_TX_FRAMER_CSUM_EN is defined.
module tb_ezusb_tx_framer;

  typedef logic [5:0][15:0]  din_t;
  typedef logic [11:0][15:0] dexp_t;

  typedef struct {
    int    n_in;
    din_t  din;
    bit    bubble;
    int    rdy;
    int    n_exp;
    dexp_t dexp;
    int    cs_a;
    int    cs_b;
    int    frames;
  } vec_t;

  logic        ifclk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] DI;
  logic        DI_valid;
  logic        DI_ready;
  logic        pktend_arm;
  logic        PKTEND;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        pk_err;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];
  logic [15:0] cur_w[8];
  bit          bubble = 1'b0;
  int          rdy_mode = 0;
  int          rcyc = 0;
  int          pk_delay = 4;
  int          pk_cnt = -1;
  int          arm_edges = 0;
  logic        arm_prev = 1'b0;
  int          exp_frames = 0;
  int          exp_edges = 0;
  vec_t        tbl[5];

  ezusb_tx_framer #(
    .MAX_LEN(4),
    .HDR_TAG(8'hA5),
    .PK_TIMEOUT(16)
  ) dut (
    .ifclk(ifclk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .DI(DI),
    .DI_valid(DI_valid),
    .DI_ready(DI_ready),
    .pktend_arm(pktend_arm),
    .PKTEND(PKTEND),
    .busy(busy),
    .frame_cnt(frame_cnt),
    .pk_err(pk_err),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial forever #5 ifclk = ~ifclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 50000 cycles, expected finish");
    $fatal(1, "watchdog");
  end

  // DI_ready pattern: 0 always ready, 1 repeating 1,0,0,1, 2 alternating 1,0
  initial begin
    DI_ready = 1'b1;
    forever begin
      @(negedge ifclk);
      case (rdy_mode)
        1: DI_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
        2: DI_ready = ((rcyc % 2) == 0);
        default: DI_ready = 1'b1;
      endcase
      rcyc++;
    end
  end

  // PKTEND responder: pulses PKTEND low pk_delay cycles after each arm edge
  initial begin
    PKTEND = 1'b1;
    forever begin
      @(negedge ifclk);
      if (!PKTEND) PKTEND = 1'b1;
      if (pktend_arm && !arm_prev) begin
        arm_edges++;
        pk_cnt = pk_delay;
      end else if (pk_cnt > 0) begin
        pk_cnt--;
        if (pk_cnt == 0) PKTEND = 1'b0;
      end
      arm_prev = pktend_arm;
    end
  end

  // scoreboard monitor: DI order and hold-under-backpressure
  logic        prev_hold = 1'b0;
  logic [15:0] prev_di = 16'h0000;
  logic [15:0] mon_e;
  initial forever begin
    @(negedge ifclk);
    #2;
    if (prev_hold) begin
      n_cmp++;
      if (!DI_valid || DI !== prev_di) begin
        n_fail++;
        $display("FAIL di_hold: got valid=%0b DI=%h expected valid=1 DI=%h", DI_valid, DI, prev_di);
      end
    end
    if (DI_valid && DI_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL di_word: got DI=%h expected no word", DI);
      end else begin
        mon_e = exp_q.pop_front();
        if (DI !== mon_e) begin
          n_fail++;
          $display("FAIL di_word: got DI=%h expected %h", DI, mon_e);
        end
      end
    end
    prev_hold = DI_valid && !DI_ready;
    prev_di   = DI;
  end

  // driver / helper tasks
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] w);
    exp_q.push_back(w);
  endtask

  task automatic push_cs(input logic [15:0] w);
`ifdef EZUSB_TX_FRAMER_CSUM_EN
    exp_q.push_back(w);
`else
    if (w === 16'hxxxx) $display("checksum word %h ignored", w);
`endif
  endtask

  // offer cur_w[0..n-1]; in_last on the final word when last_end is set
  task automatic send(input int n, input bit last_end);
    int wi = 0;
    int cyc = 0;
    while (wi < n && cyc < 400) begin
      @(negedge ifclk);
      if (bubble && (cyc % 3) == 1) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'h0000;
      end else begin
        in_valid = 1'b1;
        in_data  = cur_w[wi];
        in_last  = last_end && (wi == n - 1);
      end
      #1;
      if (in_valid && in_ready) wi++;
      cyc++;
    end
    @(negedge ifclk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'h0000;
    chk("send_accept", 32'(wi), 32'(n));
  endtask

  task automatic wait_done(input int target, input string tag);
    int cyc = 0;
    while (cyc < 500) begin
      @(negedge ifclk);
      #3;
      if (frame_cnt == 16'(target) && !busy) break;
      cyc++;
    end
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(target[15:0]));
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  function automatic din_t w6(input logic [15:0] a, b, c, d, e, f);
    return {f, e, d, c, b, a};
  endfunction

  function automatic dexp_t w12(input logic [15:0] a, b, c, d, e, f, g, h, i, j, k, l);
    return {l, k, j, i, h, g, f, e, d, c, b, a};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_DI"}, 32'(DI), 32'd0);
    chk({tag, "_DI_valid"}, 32'(DI_valid), 32'd0);
    chk({tag, "_pktend_arm"}, 32'(pktend_arm), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_pk_err"}, 32'(pk_err), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // main sequence
  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'h0000;
    repeat (3) @(negedge ifclk);
    #3;
    chk_reset_vals("rst");
    @(negedge ifclk);
    reset = 1'b0;

    // {n_in, din, bubble, rdy, n_exp, dexp, cs_a, cs_b, frames}
    tbl[0] = '{3, w6(16'h0001, 16'h0002, 16'h0003, 16'h0, 16'h0, 16'h0), 1'b0, 0, 6,
               w12(16'hA500, 16'h0001, 16'h0002, 16'h0003, 16'h0003, 16'h0006,
                   16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 5, -1, 1};
    tbl[1] = '{3, w6(16'h0001, 16'h0002, 16'h0003, 16'h0, 16'h0, 16'h0), 1'b0, 1, 6,
               w12(16'hA501, 16'h0001, 16'h0002, 16'h0003, 16'h0003, 16'h0006,
                   16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 5, -1, 1};
    tbl[2] = '{6, w6(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666), 1'b0, 0, 12,
               w12(16'hA502, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h8004,
                   16'hAAAA, 16'hA503, 16'h5555, 16'h6666, 16'h0002, 16'hBBBB), 6, 11, 2};
    tbl[3] = '{4, w6(16'hFFFF, 16'h0002, 16'h8000, 16'h8000, 16'h0, 16'h0), 1'b0, 2, 7,
               w12(16'hA504, 16'hFFFF, 16'h0002, 16'h8000, 16'h8000, 16'h0004,
                   16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 6, -1, 1};
    tbl[4] = '{1, w6(16'hBEEF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b1, 1, 4,
               w12(16'hA505, 16'hBEEF, 16'h0001, 16'hBEEF, 16'h0, 16'h0,
                   16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 3, -1, 1};

    pk_delay = 4;
    for (int v = 0; v < 5; v++) begin
      rdy_mode = tbl[v].rdy;
      bubble   = tbl[v].bubble;
      for (int k = 0; k < 6; k++) cur_w[k] = tbl[v].din[k];
      for (int k = 0; k < tbl[v].n_exp; k++) begin
        if (k == tbl[v].cs_a || k == tbl[v].cs_b) push_cs(tbl[v].dexp[k]);
        else push_exp(tbl[v].dexp[k]);
      end
      send(tbl[v].n_in, 1'b1);
      exp_frames += tbl[v].frames;
      exp_edges  += tbl[v].frames;
      wait_done(exp_frames, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_arm_edges", v), 32'(arm_edges), 32'(exp_edges));
    end
    rdy_mode = 0;
    bubble   = 1'b0;

    // reset in the middle of DATA after two payload words
    cur_w[0] = 16'h0A0A;
    cur_w[1] = 16'h0B0B;
    push_exp(16'hA506);
    push_exp(16'h0A0A);
    push_exp(16'h0B0B);
    send(2, 1'b0);
    repeat (3) @(negedge ifclk);
    #3;
    chk("abort_words_out", 32'(exp_q.size()), 32'd0);
    chk("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals("abort_rst");
    @(negedge ifclk);
    reset = 1'b0;
    exp_frames = 0;
    repeat (20) @(negedge ifclk);
    #3;
    chk("abort_no_arm", 32'(arm_edges), 32'(exp_edges));
    chk("abort_idle", 32'(busy), 32'd0);
    cur_w[0] = 16'h0042;
    push_exp(16'hA500);
    push_exp(16'h0042);
    push_exp(16'h0001);
    push_cs(16'h0042);
    send(1, 1'b1);
    exp_frames++;
    exp_edges++;
    wait_done(exp_frames, "after_abort");
    chk("after_abort_arm_edges", 32'(arm_edges), 32'(exp_edges));

    // PKTEND never arrives: timeout after 16 cycles in WAIT_PK
    pk_delay = -1;
    cur_w[0] = 16'h1234;
    push_exp(16'hA501);
    push_exp(16'h1234);
    push_exp(16'h0001);
    push_cs(16'h1234);
    send(1, 1'b1);
    begin
      int cyc = 0;
      do begin
        @(negedge ifclk);
        #3;
        cyc++;
      end while (!pktend_arm && cyc < 200);
    end
    chk("tmo_armed", 32'(pktend_arm), 32'd1);
    repeat (15) @(negedge ifclk);
    #3;
    chk("tmo_err_at15", 32'(pk_err), 32'd0);
    chk("tmo_arm_at15", 32'(pktend_arm), 32'd1);
    @(negedge ifclk);
    #3;
    chk("tmo_err_at16", 32'(pk_err), 32'd1);
    chk("tmo_arm_at16", 32'(pktend_arm), 32'd0);
    chk("tmo_idle_at16", 32'(busy), 32'd0);
    exp_frames++;
    exp_edges++;
    wait_done(exp_frames, "tmo");
    pk_delay = 4;
    cur_w[0] = 16'h5678;
    push_exp(16'hA502);
    push_exp(16'h5678);
    push_exp(16'h0001);
    push_cs(16'h5678);
    send(1, 1'b1);
    exp_frames++;
    exp_edges++;
    wait_done(exp_frames, "post_tmo");
    chk("post_tmo_arm_edges", 32'(arm_edges), 32'(exp_edges));
    chk("pk_err_sticky", 32'(pk_err), 32'd1);

    // 256 single-word frames: header low byte wraps, frame_cnt reaches 256
    reset = 1'b1;
    @(negedge ifclk);
    reset = 1'b0;
    #3;
    chk("wrap_pk_err_cleared", 32'(pk_err), 32'd0);
    exp_frames = 0;
    pk_delay = 1;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'(i * 7 + 1);
      cur_w[0] = w;
      push_exp({8'hA5, 8'(i)});
      push_exp(w);
      push_exp(16'h0001);
      push_cs(w);
      send(1, 1'b1);
      exp_frames++;
      exp_edges++;
      wait_done(exp_frames, "wrap");
    end
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'd256);
    chk("wrap_arm_edges", 32'(arm_edges), 32'(exp_edges));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ezusb_tx_framer.md
Name: ezusb_tx_framer

Overview:
- Upstream stage of the FX3 GPIF-II interface block. It feeds that block's DI / DI_valid / DI_ready / pktend_arm inputs and consumes its PKTEND output.
- Takes a user 16-bit word stream with end-of-frame marking and wraps each frame as header word, payload, length word and an optional checksum word.
- After each frame it arms a manual PKTEND and waits until PKTEND is asserted, so every frame ends on a USB packet boundary.

Parameters:
- MAX_LEN, 1024: maximum payload words per frame (1..32767); longer frames are split.
- HDR_TAG, 8'hA5: constant placed in header bits [15:8].
- PK_TIMEOUT, 65535: cycles to wait for PKTEND assertion before giving up (1..65535).

Ports:
- ifclk  input  1  interface clock; all logic on its rising edge.
- reset  input  1  asynchronous reset, active-high.
- in_data  input  16  user payload word.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks the last payload word of a frame; qualified by in_valid.
- in_ready  output  1  payload word is accepted when in_valid && in_ready.
- DI  output  16  data to the interface block.
- DI_valid  output  1  DI valid; DI and DI_valid are held while DI_ready=0.
- DI_ready  input  1  interface block accepts DI.
- pktend_arm  output  1  the 0->1 edge requests a manual PKTEND.
- PKTEND  input  1  low-active PKTEND observed from the interface block.
- busy  output  1  high in any state other than IDLE.
- frame_cnt  output  16  completed frames, wraps at 65535 -> 0.
- pk_err  output  1  sticky: a PKTEND wait timed out.

Behaviour:
- Clock and reset: one clock, ifclk. reset is asynchronous and active-high.
- Values under reset:
  - state=IDLE; DI_valid=0; DI=0; pktend_arm=0.
  - seq=0; frame_cnt=0; pk_err=0; word count=0; checksum=0.
- Reset mid-frame discards the frame. No trailer and no PKTEND are produced.
- Output register: DI/DI_valid are registered. A word "moves" on a cycle where DI_valid && DI_ready. A new word may be loaded when !DI_valid || DI_ready.
- in_ready = (state==DATA) && (!DI_valid || DI_ready). This is a combinational path from DI_ready, which is permitted.
- States:
  - IDLE: when in_valid=1, load DI={HDR_TAG, seq[7:0]}, DI_valid=1, go to HDR. in_ready=0 in this state.
  - HDR: when the header moves, go to DATA.
  - DATA: each accepted input word loads DI=in_data and increments cnt (15-bit). With CSUM_EN, csum += in_data mod 2^16.
    - Accepted word has in_last=1: go to LEN with cont=0.
    - Accepted word makes cnt==MAX_LEN without in_last: go to LEN with cont=1.
    - Bubbles on in_valid are allowed. DI_valid drops when the last loaded word moves and no new word is accepted.
  - LEN: load DI={cont, cnt[14:0]} when the register is free. When it moves, go to CSUM (if CSUM_EN) or ARM.
  - CSUM: load DI=csum. When it moves, go to ARM.
  - ARM: DI_valid must be 0. Set pktend_arm=1, clear the timer, go to WAIT_PK.
  - WAIT_PK: pktend_arm held 1.
    - PKTEND sampled 0: pktend_arm=0, seq+=1 (8-bit wrap), frame_cnt+=1, cnt=0, csum=0, go to IDLE.
    - Timer reaches PK_TIMEOUT first: same actions, plus pk_err=1.
- Split continuation: when cont=1, the next frame starts immediately from IDLE with a new header and seq+1. Remaining input words are delivered there. The first word of the continuation needs in_valid again, which is still asserted by the user.
- Frame spacing: pktend_arm returns to 0 for at least one cycle between frames, so the rising edge is always seen.
- Latency: first in_valid in IDLE -> header on DI_valid next cycle. Payload word accepted at cycle t appears on DI at t+1.
- The header and trailer are never dropped or reordered under DI_ready backpressure.

Optional Feature:
- Macro: EZUSB_TX_FRAMER_CSUM_EN.
- Defined: CSUM state present. A trailer word equal to the sum of payload words mod 65536 follows the length word.
- Undefined: the checksum register and CSUM state are removed. LEN goes directly to ARM and the frame is header+payload+length.

Test Plan:
- Frame of 3 words 0x0001,0x0002,0x0003 with last on the third, DI_ready=1, PKTEND pulled low 4 cycles after arm -> DI sequence 0xA500,0x0001,0x0002,0x0003,0x0003 (+0x0006 with CSUM_EN). One pktend_arm rising edge, frame_cnt=1, seq=1.
- Same frame with DI_ready toggled 1,0,0,1 repeatedly -> identical DI sequence, each word held stable while DI_ready=0, and no duplicated or lost words.
- MAX_LEN=4, 6-word input stream -> two frames:
  - 0xA500,w0..w3, length 0x8004 (cont=1), PKTEND.
  - 0xA501,w4,w5, length 0x0002.
- PKTEND held 1, PK_TIMEOUT=16 -> pk_err=1 exactly 16 cycles after entering WAIT_PK, pktend_arm=0, returns to IDLE, and the next frame proceeds normally.
- Assert reset during DATA after 2 words -> all outputs reach reset values immediately (asynchronous), seq=0. The next frame header is 0xA500 and no PKTEND is armed for the aborted frame.
- 256 single-word frames -> header low byte wraps 0xFF -> 0x00, frame_cnt=256.
